// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one outbound generic bus between the I-cache and
// D-cache miss paths. One transaction is latched, forwarded and answered at a time.
// Policy: fixed priority (data first) with an instruction starvation guard.
// Build option MEM_ARB_ROUND_ROBIN_EN replaces it with round-robin arbitration.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    CLK,
  input  logic                    nRST,
  // instruction requester
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_ren,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_busy,
  // data requester
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic                    d_ren,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH/8-1:0] d_byte_en,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_busy,
  // outbound bus
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH-1:0]   out_wdata,
  output logic                    out_ren,
  output logic                    out_wen,
  output logic [DATA_WIDTH/8-1:0] out_byte_en,
  input  logic [DATA_WIDTH-1:0]   out_rdata,
  input  logic                    out_busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  logic [1:0] state_q;
  logic       i_req;
  logic       d_req;
  logic       any_req;
  logic       pick_d;

  assign i_req   = i_ren;
  assign d_req   = d_ren | d_wen;
  assign any_req = i_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  logic rr_last_q;

  // Contended: grant the side that did not win last time.
  always_comb begin
    pick_d = d_req && (!i_req || (rr_last_q == SIDE_I));
  end

  // Remember the most recently granted side.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_last_q <= SIDE_D;
    end else if (state_q == IDLE && any_req) begin
      rr_last_q <= pick_d ? SIDE_D : SIDE_I;
    end
  end
`else
  localparam int unsigned CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;

  // Data wins a contended slot unless the instruction side has been starved.
  always_comb begin
    pick_d = d_req && (!i_req || (starve_cnt_q != STARVE_MAX));
  end

  // Count data grants taken while an instruction request waits; saturating.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      if (pick_d && i_ren) begin
        if (starve_cnt_q != STARVE_MAX) begin
          starve_cnt_q <= starve_cnt_q + 1'b1;
        end
      end else begin
        starve_cnt_q <= '0;
      end
    end
  end
`endif

  // Arbitration, request latching and completion tracking.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      out_addr    <= '0;
      out_wdata   <= '0;
      out_byte_en <= '0;
      out_ren     <= 1'b0;
      out_wen     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            if (pick_d) begin
              out_addr    <= d_addr;
              out_wdata   <= d_wdata;
              out_byte_en <= d_byte_en;
              out_wen     <= d_wen;
              // A simultaneous write takes precedence over the read.
              out_ren     <= d_ren & ~d_wen;
              state_q     <= GRANT_D;
            end else begin
              out_addr    <= i_addr;
              out_wdata   <= '0;
              out_byte_en <= '1;
              out_wen     <= 1'b0;
              out_ren     <= 1'b1;
              state_q     <= GRANT_I;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          // Returning to IDLE enforces the one-cycle bubble before the next grant.
          if (!out_busy) begin
            out_ren <= 1'b0;
            out_wen <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          out_ren <= 1'b0;
          out_wen <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Route the bus response only to the granted requester.
  always_comb begin
    i_busy  = 1'b1;
    d_busy  = 1'b1;
    i_rdata = '0;
    d_rdata = '0;
    if (state_q == GRANT_I) begin
      i_busy  = out_busy;
      i_rdata = out_rdata;
    end else if (state_q == GRANT_D) begin
      d_busy  = out_busy;
      d_rdata = out_rdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
// Build with MEM_ARB_ROUND_ROBIN_EN defined to exercise the round-robin policy.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end \
  end

module tb_mem_bus_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] i_addr;
  logic        i_ren;
  logic [31:0] i_rdata;
  logic        i_busy;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ren;
  logic        d_wen;
  logic [3:0]  d_byte_en;
  logic [31:0] d_rdata;
  logic        d_busy;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic        out_ren;
  logic        out_wen;
  logic [3:0]  out_byte_en;
  logic [31:0] out_rdata;
  logic        out_busy;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  mem_bus_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(8)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_addr     (i_addr),
    .i_ren      (i_ren),
    .i_rdata    (i_rdata),
    .i_busy     (i_busy),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ren      (d_ren),
    .d_wen      (d_wen),
    .d_byte_en  (d_byte_en),
    .d_rdata    (d_rdata),
    .d_busy     (d_busy),
    .out_addr   (out_addr),
    .out_wdata  (out_wdata),
    .out_ren    (out_ren),
    .out_wen    (out_wen),
    .out_byte_en(out_byte_en),
    .out_rdata  (out_rdata),
    .out_busy   (out_busy)
  );

  always #5 CLK = ~CLK;

  // Advance to 1 ns after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_rst(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL reset %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watchdog: the directed sequence must finish within a bounded time.
  initial begin
    #100000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: wait expired after %0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    nRST      = 1'b0;
    i_addr    = '0;
    i_ren     = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_ren     = 1'b0;
    d_wen     = 1'b0;
    d_byte_en = '0;
    out_rdata = '0;
    out_busy  = 1'b1;
    #2;

    // Reset state
    check_rst("out_ren", {31'h0, out_ren}, 32'h0);
    check_rst("out_wen", {31'h0, out_wen}, 32'h0);
    check_rst("out_addr", out_addr, 32'h0);
    check_rst("out_be", {28'h0, out_byte_en}, 32'h0);
    check_rst("i_busy", {31'h0, i_busy}, 32'h1);
    check_rst("d_busy", {31'h0, d_busy}, 32'h1);
    check_rst("i_rdata", i_rdata, 32'h0);
    check_rst("d_rdata", d_rdata, 32'h0);
    check_rst("state", {30'h0, dut.state_q}, 32'h0);
    tick();
    tick();
    nRST = 1'b1;
    tick();

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Round robin, both sides requesting: I, D, I, D, I, D
    i_addr = 32'h0000_0100;
    i_ren  = 1'b1;
    d_addr = 32'h0000_0200;
    d_ren  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      `CHK("rr_out_ren", out_ren, 1'b1)
      `CHK("rr_out_addr", out_addr, ((k % 2) == 0) ? 32'h0000_0100 : 32'h0000_0200)
      out_busy = 1'b0;
      tick();
      out_busy = 1'b1;
    end
    i_ren = 1'b0;
    d_ren = 1'b0;
    tick();
`endif

    // Lone instruction read
    i_addr = 32'h0000_0100;
    i_ren  = 1'b1;
    tick();
    `CHK("li_out_ren", out_ren, 1'b1)
    `CHK("li_out_wen", out_wen, 1'b0)
    `CHK("li_out_addr", out_addr, 32'h0000_0100)
    `CHK("li_out_be", out_byte_en, 4'hF)
    `CHK("li_i_busy_c1", i_busy, 1'b1)
    `CHK("li_d_busy_c1", d_busy, 1'b1)
    tick();
    `CHK("li_i_busy_c2", i_busy, 1'b1)
    tick();
    out_busy  = 1'b0;
    out_rdata = 32'hDEAD_BEEF;
    #1;
    `CHK("li_i_busy_done", i_busy, 1'b0)
    `CHK("li_i_rdata", i_rdata, 32'hDEAD_BEEF)
    `CHK("li_d_busy_done", d_busy, 1'b1)
    `CHK("li_d_rdata", d_rdata, 32'h0)
    i_ren = 1'b0;
    tick();
    `CHK("li_after_i_busy", i_busy, 1'b1)
    `CHK("li_after_out_ren", out_ren, 1'b0)
    `CHK("li_after_i_rdata", i_rdata, 32'h0)
    out_busy = 1'b1;

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Simultaneous i_ren and d_wen: data first, instruction after the bubble
    i_addr    = 32'h0000_0100;
    i_ren     = 1'b1;
    d_addr    = 32'h0000_0200;
    d_wdata   = 32'h0000_1234;
    d_byte_en = 4'h3;
    d_wen     = 1'b1;
    tick();
    `CHK("sim_d_wen", out_wen, 1'b1)
    `CHK("sim_d_ren", out_ren, 1'b0)
    `CHK("sim_d_addr", out_addr, 32'h0000_0200)
    `CHK("sim_d_wdata", out_wdata, 32'h0000_1234)
    `CHK("sim_d_be", out_byte_en, 4'h3)
    `CHK("sim_starve1", dut.starve_cnt_q, 4'd1)
    out_busy = 1'b0;
    #1;
    `CHK("sim_d_busy_done", d_busy, 1'b0)
    `CHK("sim_i_busy_held", i_busy, 1'b1)
    d_wen = 1'b0;
    tick();
    out_busy = 1'b1;
    `CHK("sim_bubble_ren", out_ren, 1'b0)
    `CHK("sim_bubble_wen", out_wen, 1'b0)
    `CHK("sim_bubble_state", dut.state_q, 2'd0)
    tick();
    `CHK("sim_i_ren", out_ren, 1'b1)
    `CHK("sim_i_addr", out_addr, 32'h0000_0100)
    `CHK("sim_i_state", dut.state_q, 2'd1)
    `CHK("sim_starve0", dut.starve_cnt_q, 4'd0)
    out_busy = 1'b0;
    i_ren    = 1'b0;
    tick();
    out_busy = 1'b1;

    // Starvation guard: 8 data grants, then the instruction side is forced
    i_addr = 32'h0000_0400;
    i_ren  = 1'b1;
    d_addr = 32'h0000_0500;
    d_ren  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      `CHK("stv_d_addr", out_addr, 32'h0000_0500)
      out_busy = 1'b0;
      tick();
      out_busy = 1'b1;
    end
    `CHK("stv_cnt_sat", dut.starve_cnt_q, 4'd8)
    tick();
    `CHK("stv_i_addr", out_addr, 32'h0000_0400)
    `CHK("stv_i_state", dut.state_q, 2'd1)
    `CHK("stv_cnt_clr", dut.starve_cnt_q, 4'd0)
    out_busy = 1'b0;
    i_ren    = 1'b0;
    d_ren    = 1'b0;
    tick();
    out_busy = 1'b1;
`endif

    // d_ren and d_wen together; later request changes ignored; drop mid-transaction
    d_addr    = 32'h0000_0300;
    d_wdata   = 32'hAAAA_5555;
    d_byte_en = 4'hF;
    d_ren     = 1'b1;
    d_wen     = 1'b1;
    tick();
    `CHK("rw_out_wen", out_wen, 1'b1)
    `CHK("rw_out_ren", out_ren, 1'b0)
    `CHK("rw_out_addr", out_addr, 32'h0000_0300)
    d_addr  = 32'h0000_0999;
    d_wdata = 32'h1111_1111;
    tick();
    `CHK("rw_hold_addr", out_addr, 32'h0000_0300)
    `CHK("rw_hold_wdata", out_wdata, 32'hAAAA_5555)
    d_ren = 1'b0;
    d_wen = 1'b0;
    tick();
    `CHK("rw_drop_wen", out_wen, 1'b1)
    out_busy = 1'b0;
    tick();
    `CHK("rw_done_wen", out_wen, 1'b0)
    `CHK("rw_done_state", dut.state_q, 2'd0)

    // out_busy low while idle with no request is ignored
    tick();
    `CHK("idle_busy_state", dut.state_q, 2'd0)
    `CHK("idle_busy_ren", out_ren, 1'b0)
    `CHK("idle_busy_d_busy", d_busy, 1'b1)
    out_busy = 1'b1;

    // Asynchronous reset during GRANT_D with out_wen high
    d_addr  = 32'h0000_0600;
    d_wdata = 32'h0000_00AB;
    d_wen   = 1'b1;
    tick();
    `CHK("ar_pre_wen", out_wen, 1'b1)
    #2;
    nRST = 1'b0;
    #1;
    `CHK("ar_out_wen", out_wen, 1'b0)
    `CHK("ar_out_addr", out_addr, 32'h0)
    `CHK("ar_d_busy", d_busy, 1'b1)
    d_wen = 1'b0;
    #2;
    nRST = 1'b1;
    tick();
    `CHK("ar_state", dut.state_q, 2'd0)
    `CHK("ar_post_wen", out_wen, 1'b0)

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
